// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, reset PC and the fetch FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam word_t PC_RESET = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding a fetched instruction and its next address
// while IF/ID is stalled.
module fetch_skid_buf
   import cpu_types_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  load_i,
   input  logic  clear_i,
   input  word_t instr_i,
   input  word_t npc_i,
   output logic  valid_o,
   output word_t instr_o,
   output word_t npc_o
);

   logic  valid_q;
   word_t instr_q;
   word_t npc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         npc_q   <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         npc_q   <= npc_i;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to the icache and feeds
// the IF/ID register, absorbing stalls, redirects and halt.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t       PC_INIT = PC_RESET,
   parameter int unsigned PC_STEP = 4
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  ihit,
   input  word_t imemload,
   output logic  imemREN,
   output word_t imemaddr,
   input  logic  stall,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  halt,
   output word_t ifid_instruction,
   output word_t ifid_next_address,
   output logic  ifid_WEN,
   output logic  ifid_flush,
   output word_t fetch_pc
);

   localparam word_t STEP = word_t'(PC_STEP);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        target_q, target_d;
   logic         halt_q;

   logic  buf_load, buf_clear, buf_valid;
   word_t buf_instr, buf_npc;
   word_t npc;
   logic  halt_any;

   assign npc      = pc_q + STEP;
   assign halt_any = halt | halt_q;

   fetch_skid_buf u_buf (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .instr_i (imemload),
      .npc_i   (npc),
      .valid_o (buf_valid),
      .instr_o (buf_instr),
      .npc_o   (buf_npc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= FETCH;
         pc_q     <= PC_INIT;
         target_q <= '0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         halt_q   <= halt_q | halt;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      target_d  = target_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               if (ihit) begin
                  pc_d = redirect_pc;
               end else begin
                  target_d = redirect_pc;
                  state_d  = DRAIN;
               end
            end else if (ihit) begin
               if (halt_any) begin
                  state_d = HALTED;
               end else if (stall) begin
                  buf_load = 1'b1;
                  pc_d     = npc;
                  state_d  = HOLD;
               end else begin
                  pc_d = npc;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               buf_clear = 1'b1;
               pc_d      = redirect_pc;
               state_d   = FETCH;
            end else if (halt_any) begin
               state_d = HALTED;
            end else if (!stall) begin
               buf_clear = 1'b1;
               state_d   = FETCH;
            end
         end
         DRAIN: begin
            // the outstanding request must complete before retargeting
            if (ihit) begin
               pc_d    = redirect ? redirect_pc : target_q;
               state_d = halt_any ? HALTED : FETCH;
            end else if (redirect) begin
               target_d = redirect_pc;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_comb begin
      imemREN           = 1'b0;
      imemaddr          = '0;
      ifid_instruction  = '0;
      ifid_next_address = '0;
      ifid_WEN          = 1'b0;
      ifid_flush        = 1'b0;
      if (!RST) begin
         ifid_flush        = redirect;
         ifid_instruction  = imemload;
         ifid_next_address = npc;
         unique case (state_q)
            FETCH: begin
               imemREN  = 1'b1;
               imemaddr = pc_q;
               ifid_WEN = ihit & ~redirect & ~halt_any & ~stall;
            end
            HOLD: begin
               ifid_instruction  = buf_instr;
               ifid_next_address = buf_npc;
               ifid_WEN = buf_valid & ~redirect & ~halt_any & ~stall;
            end
            DRAIN: begin
               imemREN  = 1'b1;
               imemaddr = pc_q;
            end
            HALTED: begin
               imemREN = 1'b0;
            end
            default: begin
               imemREN = 1'b0;
            end
         endcase
      end
   end

   assign fetch_pc = pc_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues requests to the instruction cache, and produces the instruction_in, next_address_in, WEN and flush inputs of the IF/ID pipeline register. It absorbs icache latency, hazard-unit stalls, branch/jump redirects and halt. A one-entry buffer holds a returned instruction while IF/ID is stalled.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment to the sequential next PC.

Ports:
CLK  in  1  clock; one clock domain for the whole block.
RST  in  1  reset; synchronous and active-high.
ihit  in  1  icache: imemload valid this cycle for imemaddr.
imemload  in  32  icache instruction word.
imemREN  out  1  icache read request.
imemaddr  out  32  icache address; must stay stable while imemREN=1 until ihit.
stall  in  1  hazard unit: IF/ID must not load.
redirect  in  1  branch/jump resolved taken; squash the younger fetch.
redirect_pc  in  32  redirect target.
halt  in  1  halt decoded; stop fetching.
ifid_instruction  out  32  to IF/ID instruction_in.
ifid_next_address  out  32  to IF/ID next_address_in (fetched PC + PC_STEP).
ifid_WEN  out  1  to IF/ID WEN.
ifid_flush  out  1  to IF/ID flush (NOP insert).
fetch_pc  out  32  current PC (debug/trace).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Registers: pc, state, buf_instr, buf_npc, target_q, halt_q.
- While RST=1: pc<=PC_INIT, state<=FETCH, buffers and target_q<=0, halt_q<=0. All outputs 0 except fetch_pc=pc.
- In the first cycle after RST falls: imemREN=1 and imemaddr=PC_INIT.
- ifid_flush=redirect in every state other than reset, combinationally. Nothing else is delayed.
- Priority within every state: redirect > halt > stall.
- halt_q is sticky (set on halt=1) and is cleared only by RST.
- FETCH: imemREN=1, imemaddr=pc.
  - ihit & redirect: discard data; pc<=redirect_pc; stay FETCH.
  - !ihit & redirect: target_q<=redirect_pc; go DRAIN.
  - ihit & (halt|halt_q): discard data; go HALTED.
  - ihit & !stall: ifid_WEN=1, ifid_instruction=imemload, ifid_next_address=pc+PC_STEP; pc<=pc+PC_STEP. Gives 1 instruction/cycle with ihit constantly high.
  - ihit & stall: buf_instr<=imemload, buf_npc<=pc+PC_STEP, pc<=pc+PC_STEP; go HOLD.
  - !ihit: hold pc.
- HOLD: imemREN=0; ifid_instruction=buf_instr, ifid_next_address=buf_npc.
  - redirect: drop buffer; pc<=redirect_pc; go FETCH.
  - halt|halt_q: go HALTED.
  - !stall: ifid_WEN=1; go FETCH. Next request is issued the following cycle.
- DRAIN: completes the outstanding request without changing the address. imemREN=1, imemaddr=pc, ifid_WEN=0.
  - A further redirect overwrites target_q.
  - On ihit: discard data; pc<=target_q (or redirect_pc if redirect is high that cycle); go FETCH, or HALTED if halt_q.
- HALTED: imemREN=0, ifid_WEN=0; only RST exits.
- Arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000. redirect_pc is used unmodified.
- Outside HOLD, ifid_instruction/ifid_next_address follow imemload/pc+PC_STEP. Their values are don't-care when ifid_WEN=0.
- RST mid-request overrides everything, including DRAIN; the abandoned icache request is the cache's concern.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {FETCH, HOLD, DRAIN, HALTED}.
  - Constant PC_RESET used as the PC_INIT default.
  - word_t is reused for all 32-bit ports.
- Sub-module fetch_skid_buf: one-entry instruction/next-address buffer with load, valid and clear.
- PC update and FSM stay in fetch_stage.

Test Plan:
- Reset, then ihit=1 constant, stall=0 -> imemaddr 0x0,0x4,0x8 on consecutive cycles; ifid_WEN=1 each cycle; ifid_next_address 0x4,0x8,0xC.
- At pc=0x10, ihit=1, stall=1 for 3 cycles, imemload=0x8C220004 -> imemREN=0 for those cycles; stall drop gives one ifid_WEN pulse with 0x8C220004 and next_address 0x14; next imemaddr=0x14.
- At pc=0x20, ihit=0, redirect=1, redirect_pc=0x100 -> ifid_flush=1 that cycle; imemaddr stays 0x20 until ihit; data discarded (no WEN); next imemaddr=0x100.
- In HOLD, redirect=1, redirect_pc=0x40 -> buffer dropped, no WEN, flush=1; next cycle imemaddr=0x40.
- halt=1 while request at pc=0x30 is outstanding, ihit after 2 cycles -> no WEN; imemREN=0 permanently; fetch_pc stays 0x30 until RST.
- RST=1 asserted while in DRAIN -> next cycle state FETCH, imemaddr=0x0, target_q ignored.
